dist16b6: RTL and testbench
===========================

# dist16b6

Six-destination 16-bit write distributor: accepts one word plus a 3-bit destination select over a valid/ready handshake and delivers it to exactly one of six output ports, each with its own valid/ready handshake. It is the fan-out counterpart of the six-input 16-bit select mux and sits on the processor's write-back/result path, steering results to register-file, memory-data, and I/O sinks. It uses a one-entry pipeline register, so throughput is one word per cycle. Out-of-range selects are trapped and counted rather than silently ignored.

## Interface
Parameters:
- DATA_W, 16, word width
- SEL_W, 3, select width
- NUM_DEST, 6, number of destination ports; legal selects are 0..NUM_DEST-1
- ERR_CNT_W, 8, error counter width

Ports:
- clk, input, 1, single clock; all state changes on the rising edge
- rst_n, input, 1, asynchronous active-low reset
- in_valid, input, 1, source word present
- in_ready, output, 1, block will accept the word this cycle
- in_data, input, 16, source word
- in_select, input, 3, destination index
- out0 … out5, output, 16 each, destination data
- out_valid, output, 6, one-hot destination valid
- out_ready, input, 6, per-destination ready
- err_flag, output, 1, sticky flag: an out-of-range select has been seen
- err_select, output, 3, select value of the most recent error
- err_count, output, 8, saturating count of out-of-range selects
- err_clr, input, 1, synchronous clear of err_flag, err_select, and err_count
- deliver_count, output, 16, wrapping count of completed output handshakes

## Operation
- Accept condition: in_valid && in_ready.
- The holding register contains data_q, sel_q, and full.
- FSM states:
  - EMPTY: full=0.
  - FULL: full=1.
- in_ready = !full || out_ready[sel_q]. This allows simultaneous drain and refill. in_ready is forced to 0 while rst_n is low.
- Accept with in_select < 6:
  - Load data_q and sel_q, and set full=1.
- Accept with in_select of 6 or 7:
  - The word is consumed and dropped; the holding register is unchanged.
  - Set err_flag and load err_select.
  - Increment err_count, saturating at 255.
- Output handshake (drain) condition: full && out_ready[sel_q].
  - On drain, full returns to 0 unless the same cycle also loads a legal word.
  - deliver_count increments by 1 per drain and wraps from 16'hFFFF to 0.
- Output ports while full:
  - out_valid = one-hot(sel_q).
  - out[sel_q] = data_q.
  - All non-selected outN ports drive 16'h0000.
- Output ports while empty: out_valid = 0 and all outN ports = 0.
- out_ready on non-selected destinations is ignored.
- While a port is valid and not ready, its data and valid are held stable.
- err_clr:
  - Clears err_flag, err_select, and err_count.
  - If a new error is accepted in the same cycle, the error wins: err_flag=1, err_select=new value, err_count=1.
- An illegal-select accept in the same cycle as a drain: the drain completes, the block goes EMPTY, and the error is logged.

## Timing
- Reset (asynchronous): full=0, data_q=0, sel_q=0, all out* = 0, out_valid=0, err_flag=0, err_select=0, err_count=0, deliver_count=0.
- If reset asserts mid-transfer, the held word is discarded without a handshake.
- Latency: a word accepted at edge N is visible on out_valid/outN in the cycle after edge N (one cycle). The earliest drain is at edge N+1.
- Throughput: one word per cycle when the destination ready is continuously high.
- Back-pressure:
  - A stalled destination stalls all destinations, because the holding register is shared.
  - No reordering is possible.
- Error outputs are registered and update one edge after the offending accept.

## Structure
- Package dist16_pkg holds DATA_W, SEL_W, NUM_DEST, ERR_CNT_W, the FSM state enum {EMPTY, FULL}, and the legal-select compare function.
- One sub-module, sat_counter (parameterised width, increment and clear inputs, saturates at all-ones), is used for err_count.
- deliver_count is a plain wrapping register and lives in the top level.

## Test plan
- Reset, then accept 16'hA5A5 with select 3 and out_ready=6'b111111: out_valid=6'b001000 and out3=16'hA5A5 one cycle later; all other outN = 0; deliver_count=1.
- Stream six words 16'h0010..16'h0015 with selects 0..5 and all ready high: one delivery per cycle to ports 0..5 in order; in_ready stays 1; deliver_count=6.
- Hold word 16'h1234 to port 2 with out_ready[2]=0 for 4 cycles while out_ready on all other ports is high:
  - in_ready=0 and out2 is stable throughout.
  - Raising out_ready[2] drains the word and accepts the next word in the same cycle.
- Illegal selects:
  - Send select 6, then select 7: no out_valid; err_flag=1, err_select=7, err_count=2.
  - 300 illegal selects leave err_count=255.
  - err_clr together with an illegal select gives err_count=1.
- Reset asynchronously while FULL (holding 16'hBEEF to port 5): out_valid is 0 immediately, without waiting for a clock edge; after release, in_ready=1 and deliver_count=0.

Source files
------------

// File: rtl/dist16_pkg.sv
// Shared widths, FSM state type and select-legality helper for the
// six-destination 16-bit write distributor.
package dist16_pkg;

   localparam int DATA_W    = 16;
   localparam int SEL_W     = 3;
   localparam int NUM_DEST  = 6;
   localparam int ERR_CNT_W = 8;

   typedef enum logic {
      EMPTY = 1'b0,
      FULL  = 1'b1
   } state_t;

   function automatic logic is_legal_sel(input logic [SEL_W-1:0] sel);
      return sel < SEL_W'(NUM_DEST);
   endfunction

endpackage

// File: rtl/dist16b6_sat_counter.sv
// Saturating up-counter with synchronous clear; an increment in the same
// cycle as a clear yields one. Registered output, no backpressure.
module sat_counter #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         i_inc,
   input  logic         i_clr,
   output logic [W-1:0] o_count
);

   logic [W-1:0] r_count;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_count <= '0;
      end else if (i_clr && i_inc) begin
         r_count <= W'(1);
      end else if (i_clr) begin
         r_count <= '0;
      end else if (i_inc && (r_count != '1)) begin
         r_count <= r_count + W'(1);
      end
   end

   assign o_count = r_count;

endmodule

// File: rtl/dist16b6.sv
// Six-way 16-bit write distributor: one-entry holding register, one cycle latency,
// one word/cycle; a stalled destination stalls input, illegal selects are dropped and logged.
module dist16b6
   import dist16_pkg::*;
(
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [DATA_W-1:0]     in_data,
   input  logic [SEL_W-1:0]      in_select,
   output logic [DATA_W-1:0]     out0,
   output logic [DATA_W-1:0]     out1,
   output logic [DATA_W-1:0]     out2,
   output logic [DATA_W-1:0]     out3,
   output logic [DATA_W-1:0]     out4,
   output logic [DATA_W-1:0]     out5,
   output logic [NUM_DEST-1:0]   out_valid,
   input  logic [NUM_DEST-1:0]   out_ready,
   output logic                  err_flag,
   output logic [SEL_W-1:0]      err_select,
   output logic [ERR_CNT_W-1:0]  err_count,
   input  logic                  err_clr,
   output logic [15:0]           deliver_count
);

   state_t                 r_state;
   state_t                 w_state_nxt;
   logic [DATA_W-1:0]      r_data;
   logic [SEL_W-1:0]       r_sel;
   logic                   r_err_flag;
   logic [SEL_W-1:0]       r_err_sel;
   logic [15:0]            r_deliver_cnt;

   logic                   w_full;
   logic                   w_accept;
   logic                   w_legal;
   logic                   w_load;
   logic                   w_err;
   logic                   w_drain;
   logic                   w_sel_rdy;
   logic [(1<<SEL_W)-1:0]  w_rdy_ext;
   logic [DATA_W-1:0]      w_out [NUM_DEST];

   // Pad ready out to the full select range so any sel_q indexes safely.
   assign w_rdy_ext = {{((1 << SEL_W) - NUM_DEST){1'b0}}, out_ready};
   assign w_sel_rdy = w_rdy_ext[r_sel];
   assign w_full    = (r_state == FULL);
   assign w_accept  = in_valid && in_ready;
   assign w_legal   = is_legal_sel(in_select);
   assign w_load    = w_accept && w_legal;
   assign w_err     = w_accept && !w_legal;
   assign w_drain   = w_full && w_sel_rdy;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= EMPTY;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      if (w_load) begin
         w_state_nxt = FULL;
      end else if (w_drain) begin
         w_state_nxt = EMPTY;
      end
   end

   always_comb begin
      in_ready  = rst_n && (!w_full || w_sel_rdy);
      out_valid = '0;
      for (int k = 0; k < NUM_DEST; k++) begin
         w_out[k] = '0;
         if (w_full && (r_sel == SEL_W'(k))) begin
            out_valid[k] = 1'b1;
            w_out[k]     = r_data;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_data <= '0;
         r_sel  <= '0;
      end else if (w_load) begin
         r_data <= in_data;
         r_sel  <= in_select;
      end
   end

   // A new error outranks a same-cycle clear.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_err_flag <= 1'b0;
         r_err_sel  <= '0;
      end else if (w_err) begin
         r_err_flag <= 1'b1;
         r_err_sel  <= in_select;
      end else if (err_clr) begin
         r_err_flag <= 1'b0;
         r_err_sel  <= '0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_deliver_cnt <= '0;
      end else if (w_drain) begin
         r_deliver_cnt <= r_deliver_cnt + 16'd1;
      end
   end

   sat_counter #(
      .W (ERR_CNT_W)
   ) u_err_cnt (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_inc   (w_err),
      .i_clr   (err_clr),
      .o_count (err_count)
   );

   assign out0          = w_out[0];
   assign out1          = w_out[1];
   assign out2          = w_out[2];
   assign out3          = w_out[3];
   assign out4          = w_out[4];
   assign out5          = w_out[5];
   assign err_flag      = r_err_flag;
   assign err_select    = r_err_sel;
   assign deliver_count = r_deliver_cnt;

endmodule

// File: tb/tb_dist16b6.sv
// Directed self-checking bench for dist16b6: inputs change on the falling
// edge, outputs are compared on the falling edge (after the rising edge).
module tb_dist16b6;

   logic        clk;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] in_data;
   logic [2:0]  in_select;
   logic [15:0] out0, out1, out2, out3, out4, out5;
   logic [5:0]  out_valid;
   logic [5:0]  out_ready;
   logic        err_flag;
   logic [2:0]  err_select;
   logic [7:0]  err_count;
   logic        err_clr;
   logic [15:0] deliver_count;

   logic [15:0] outs [6];
   int          checks;
   int          failures;

   assign outs[0] = out0;
   assign outs[1] = out1;
   assign outs[2] = out2;
   assign outs[3] = out3;
   assign outs[4] = out4;
   assign outs[5] = out5;

   dist16b6 dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .in_valid      (in_valid),
      .in_ready      (in_ready),
      .in_data       (in_data),
      .in_select     (in_select),
      .out0          (out0),
      .out1          (out1),
      .out2          (out2),
      .out3          (out3),
      .out4          (out4),
      .out5          (out5),
      .out_valid     (out_valid),
      .out_ready     (out_ready),
      .err_flag      (err_flag),
      .err_select    (err_select),
      .err_count     (err_count),
      .err_clr       (err_clr),
      .deliver_count (deliver_count)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   initial begin
      checks    = 0;
      failures  = 0;
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      in_data   = 16'h0000;
      in_select = 3'd0;
      out_ready = 6'b000000;
      err_clr   = 1'b0;

      #3;
      chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
      chk("rst_out_valid", {26'd0, out_valid}, 32'd0);
      chk("rst_err_flag", {31'd0, err_flag}, 32'd0);
      chk("rst_err_count", {24'd0, err_count}, 32'd0);
      chk("rst_deliver", {16'd0, deliver_count}, 32'd0);
      #9 rst_n = 1'b1;

      // Single word to port 3
      @(negedge clk);
      in_valid = 1'b1; in_data = 16'hA5A5; in_select = 3'd3; out_ready = 6'b111111;
      #1 chk("t1_in_ready", {31'd0, in_ready}, 32'd1);
      @(negedge clk);
      chk("t1_out_valid", {26'd0, out_valid}, 32'h08);
      chk("t1_out3", {16'd0, out3}, 32'hA5A5);
      chk("t1_out0", {16'd0, out0}, 32'h0);
      chk("t1_out5", {16'd0, out5}, 32'h0);
      in_valid = 1'b0;
      @(negedge clk);
      chk("t1_deliver", {16'd0, deliver_count}, 32'd1);
      chk("t1_empty", {26'd0, out_valid}, 32'd0);

      // Back-to-back stream to ports 0..5
      for (int i = 0; i < 6; i++) begin
         if (i > 0) begin
            chk("t2_out_valid", {26'd0, out_valid}, 32'd1 << (i - 1));
            chk("t2_out_data", {16'd0, outs[i-1]}, 32'h10 + 32'(i - 1));
         end
         in_valid = 1'b1; in_data = 16'h0010 + 16'(i); in_select = 3'(i);
         #1 chk("t2_in_ready", {31'd0, in_ready}, 32'd1);
         @(negedge clk);
      end
      in_valid = 1'b0;
      chk("t2_last_valid", {26'd0, out_valid}, 32'h20);
      chk("t2_last_data", {16'd0, out5}, 32'h15);
      @(negedge clk);
      chk("t2_deliver", {16'd0, deliver_count}, 32'd7);

      // Stall on port 2, then drain and refill in the same cycle
      in_valid = 1'b1; in_data = 16'h1234; in_select = 3'd2; out_ready = 6'b111011;
      @(negedge clk);
      in_data = 16'h5678; in_select = 3'd4;
      for (int i = 0; i < 4; i++) begin
         #1;
         chk("t3_stall_in_ready", {31'd0, in_ready}, 32'd0);
         chk("t3_stall_out2", {16'd0, out2}, 32'h1234);
         chk("t3_stall_valid", {26'd0, out_valid}, 32'h04);
         @(negedge clk);
      end
      out_ready = 6'b111111;
      #1 chk("t3_release_in_ready", {31'd0, in_ready}, 32'd1);
      @(negedge clk);
      chk("t3_refill_valid", {26'd0, out_valid}, 32'h10);
      chk("t3_refill_out4", {16'd0, out4}, 32'h5678);
      chk("t3_refill_out2", {16'd0, out2}, 32'h0);
      chk("t3_deliver_a", {16'd0, deliver_count}, 32'd8);
      in_valid = 1'b0;
      @(negedge clk);
      chk("t3_deliver_b", {16'd0, deliver_count}, 32'd9);

      // Illegal selects
      in_valid = 1'b1; in_data = 16'hDEAD; in_select = 3'd6;
      @(negedge clk);
      chk("t4_sel6_valid", {26'd0, out_valid}, 32'd0);
      chk("t4_sel6_flag", {31'd0, err_flag}, 32'd1);
      chk("t4_sel6_sel", {29'd0, err_select}, 32'd6);
      chk("t4_sel6_cnt", {24'd0, err_count}, 32'd1);
      in_select = 3'd7;
      @(negedge clk);
      chk("t4_sel7_valid", {26'd0, out_valid}, 32'd0);
      chk("t4_sel7_sel", {29'd0, err_select}, 32'd7);
      chk("t4_sel7_cnt", {24'd0, err_count}, 32'd2);
      for (int i = 0; i < 253; i++) @(negedge clk);
      chk("t4_cnt_255", {24'd0, err_count}, 32'd255);
      for (int i = 0; i < 45; i++) @(negedge clk);
      chk("t4_cnt_sat", {24'd0, err_count}, 32'd255);
      chk("t4_deliver_same", {16'd0, deliver_count}, 32'd9);
      err_clr = 1'b1; in_select = 3'd6;
      @(negedge clk);
      chk("t4_clr_err_cnt", {24'd0, err_count}, 32'd1);
      chk("t4_clr_err_flag", {31'd0, err_flag}, 32'd1);
      chk("t4_clr_err_sel", {29'd0, err_select}, 32'd6);
      in_valid = 1'b0;
      @(negedge clk);
      chk("t4_clr_cnt", {24'd0, err_count}, 32'd0);
      chk("t4_clr_flag", {31'd0, err_flag}, 32'd0);
      chk("t4_clr_sel", {29'd0, err_select}, 32'd0);
      err_clr = 1'b0;

      // Illegal accept coinciding with a drain
      in_valid = 1'b1; in_data = 16'h7777; in_select = 3'd1;
      @(negedge clk);
      chk("t5_full_valid", {26'd0, out_valid}, 32'h02);
      in_select = 3'd7;
      #1 chk("t5_in_ready", {31'd0, in_ready}, 32'd1);
      @(negedge clk);
      chk("t5_empty", {26'd0, out_valid}, 32'd0);
      chk("t5_err_cnt", {24'd0, err_count}, 32'd1);
      chk("t5_deliver", {16'd0, deliver_count}, 32'd10);
      in_valid = 1'b0;

      // Asynchronous reset while holding a word
      in_valid = 1'b1; in_data = 16'hBEEF; in_select = 3'd5; out_ready = 6'b000000;
      @(negedge clk);
      chk("t6_full_valid", {26'd0, out_valid}, 32'h20);
      chk("t6_full_out5", {16'd0, out5}, 32'hBEEF);
      in_valid = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      chk("t6_async_valid", {26'd0, out_valid}, 32'd0);
      chk("t6_async_out5", {16'd0, out5}, 32'h0);
      chk("t6_async_in_ready", {31'd0, in_ready}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1; out_ready = 6'b111111;
      #1;
      chk("t6_post_in_ready", {31'd0, in_ready}, 32'd1);
      chk("t6_post_deliver", {16'd0, deliver_count}, 32'd0);
      chk("t6_post_err_cnt", {24'd0, err_count}, 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
